// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
//   Shared types and constants for the fetch front end: the fetch state
//   encoding, the reset PC default and the NOP instruction used on flush.
package fetch_pc_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } fetch_state_e;

  // Instructions are word aligned; any set bit in [1:0] is a bad target.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Bundles the program-memory bus, the execute redirect request and the
//   IF->ID slot handshake of the fetch unit.
//   master : the fetch unit (drives address, slot outputs, status)
//   slave  : the environment (memory, execute, decode)
interface fetch_pc_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] Mem_Address_o;
  logic [DATA_WIDTH-1:0] Mem_Instruction_i;
  logic                  Redirect_i;
  logic [DATA_WIDTH-1:0] Redirect_Target_i;
  logic                  ID_Ready_i;
  logic                  IF_Valid_o;
  logic [DATA_WIDTH-1:0] IF_PC_o;
  logic [DATA_WIDTH-1:0] IF_PC_Plus4_o;
  logic [DATA_WIDTH-1:0] IF_Instruction_o;
  logic                  Misaligned_o;
  logic [DATA_WIDTH-1:0] Fetch_Count_o;

  modport master (
    output Mem_Address_o,
    input  Mem_Instruction_i,
    input  Redirect_i,
    input  Redirect_Target_i,
    input  ID_Ready_i,
    output IF_Valid_o,
    output IF_PC_o,
    output IF_PC_Plus4_o,
    output IF_Instruction_o,
    output Misaligned_o,
    output Fetch_Count_o
  );

  modport slave (
    input  Mem_Address_o,
    output Mem_Instruction_i,
    output Redirect_i,
    output Redirect_Target_i,
    output ID_Ready_i,
    input  IF_Valid_o,
    input  IF_PC_o,
    input  IF_PC_Plus4_o,
    input  IF_Instruction_o,
    input  Misaligned_o,
    input  Fetch_Count_o
  );

endinterface

// File: rtl/fetch_pc_unit_if_id_slot.sv
// fetch_pc_unit_if_id_slot
//   Valid/ready pipeline register between fetch and decode. Holds the PC,
//   PC+4 and the instruction of one fetched word.
//   clk, reset      : clock, async active-low reset
//   load_i          : capture pc_i/pc_plus4_i/instr_i and mark valid
//   flush_i         : invalidate and replace the instruction with NOP
//   valid_o, pc_o, pc_plus4_o, instr_o : slot contents
//   Neither load nor flush -> contents hold.
module fetch_pc_unit_if_id_slot #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instr_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;

  // Flush wins over load; PC fields are left untouched on flush since
  // they are meaningless while the slot is invalid.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d    = 1'b1;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      instr_d    = instr_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch front end: owns the PC, drives the program memory address and
//   loads the returned word into the IF->ID slot. Handles redirects from
//   execute (flush + new PC) and parks in TRAP on a misaligned target.
//   clk   : core clock
//   reset : async active-low reset
//   bus   : fetch_pc_unit_if.master (memory bus, redirect, slot handshake,
//           misaligned status, fetch counter)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | one bubble cycle after reset, no fetch
//   RUN   | fetch whenever the slot is free
//   TRAP  | misaligned redirect seen; fetch stopped until aligned redirect
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_unit_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] COUNT_ONE = DATA_WIDTH'(1);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  mis_q, mis_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  slot_valid;
  logic                  slot_free;
  logic                  slot_load;
  logic                  slot_flush;

  assign pc_plus4  = pc_q + PC_STEP;  // wraps silently at the top of memory
  assign slot_free = !slot_valid || bus.ID_Ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;
    // A redirect beats everything else, including the boot bubble and a
    // decode stall; the slot is flushed and nothing is fetched this cycle.
    if (bus.Redirect_i) begin
      slot_flush = 1'b1;
      pc_d       = bus.Redirect_Target_i;
      if (word_aligned(bus.Redirect_Target_i[1:0])) begin
        state_d = ST_RUN;
        mis_d   = 1'b0;
      end else begin
        state_d = ST_TRAP;
        mis_d   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (slot_free) begin
            slot_load = 1'b1;
            pc_d      = pc_plus4;
            cnt_d     = cnt_q + COUNT_ONE;
          end
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  fetch_pc_unit_if_id_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load_i     (slot_load),
    .flush_i    (slot_flush),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_i    (bus.Mem_Instruction_i),
    .valid_o    (slot_valid),
    .pc_o       (bus.IF_PC_o),
    .pc_plus4_o (bus.IF_PC_Plus4_o),
    .instr_o    (bus.IF_Instruction_o)
  );

  assign bus.Mem_Address_o = pc_q;
  assign bus.IF_Valid_o    = slot_valid;
  assign bus.Misaligned_o  = mis_q;
  assign bus.Fetch_Count_o = cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Front end of the core's fetch path. It owns the program counter, drives the program memory address, and captures the returned instruction into a registered IF output slot. The slot has a valid/ready handshake toward decode. It accepts branch/jump redirects from execute, flushes on redirect, and traps on misaligned targets.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction.
RESET_PC, 32'h0040_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction value (addi x0,x0,0) placed in the slot on reset and on flush.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-low reset.
Mem_Address_o  output  DATA_WIDTH  byte address to program memory; equals the PC register, combinational.
Mem_Instruction_i  input  DATA_WIDTH  instruction returned combinationally by program memory for Mem_Address_o.
Redirect_i  input  1  branch/jump taken; single-cycle request.
Redirect_Target_i  input  DATA_WIDTH  new PC when Redirect_i is high.
ID_Ready_i  input  1  decode accepts the slot this cycle.
IF_Valid_o  output  1  slot holds a valid instruction.
IF_PC_o  output  DATA_WIDTH  PC of the slot instruction.
IF_PC_Plus4_o  output  DATA_WIDTH  IF_PC_o + 4, modulo 2^32.
IF_Instruction_o  output  DATA_WIDTH  slot instruction.
Misaligned_o  output  1  high while in TRAP.
Fetch_Count_o  output  DATA_WIDTH  number of instructions loaded into the slot; wraps modulo 2^32.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=BOOT, IF_Valid_o=0, IF_PC_o=0, IF_PC_Plus4_o=0.
  - IF_Instruction_o=NOP_INSTR, Misaligned_o=0, Fetch_Count_o=0.
- States:
  - BOOT: no fetch for one cycle; goes to RUN unconditionally (one-bubble boot).
  - RUN: normal fetch.
  - TRAP: fetching stopped.
- Slot-free condition: slot_free = !IF_Valid_o || ID_Ready_i.
- RUN without redirect:
  - If slot_free: slot <= {pc, pc+4, Mem_Instruction_i}, IF_Valid_o<=1, pc<=pc+4, Fetch_Count_o+=1. Fetch-to-slot latency is 1 cycle.
  - Otherwise everything holds. Slot contents must remain stable while IF_Valid_o=1 and ID_Ready_i=0.
  - Valid slot + ID_Ready_i=1 in the same cycle: consume and refill on the same edge (full throughput, one instruction per cycle).
- Redirect_i=1 has priority over fetch and stall, in any state including BOOT:
  - IF_Valid_o<=0 and IF_Instruction_o<=NOP_INSTR (flush), regardless of ID_Ready_i. No fetch that cycle; the count is not incremented.
  - Aligned target (Redirect_Target_i[1:0]==0): pc<=target, state<=RUN.
  - Misaligned target: pc<=target, state<=TRAP, Misaligned_o<=1.
- TRAP:
  - IF_Valid_o stays 0 and pc holds.
  - Leaves only on a redirect to an aligned target: next state RUN, Misaligned_o<=0.
  - A further misaligned redirect keeps TRAP.
- Arithmetic: pc+4 wraps; 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- ID_Ready_i is ignored when IF_Valid_o=0.
- Reset asserted mid-operation immediately forces all reset values. The first fetch occurs on the second rising edge after reset deasserts.

Decomposition:
- Shared package: fetch state enum (BOOT, RUN, TRAP), RESET_PC default, NOP_INSTR constant, XLEN=32.
- One natural sub-module: if_id_slot. It is the valid/ready pipeline register holding PC, PC+4 and instruction, with load, flush and hold controls.
- The PC register, FSM and counter stay in fetch_pc_unit.

Test Plan:
- Reset release, ID_Ready_i=1, memory returns word index as data -> cycle 1 bubble; from cycle 2, IF_PC_o = 0x00400000, 0x00400004, ... every cycle, IF_Valid_o=1, Fetch_Count_o increments by 1 per cycle.
- Hold ID_Ready_i=0 for 3 cycles while the slot holds PC 0x00400008 -> slot is stable, Mem_Address_o=0x0040000C, count unchanged; on release the next slot is 0x0040000C.
- Redirect_i with target 0x00400100 while the slot is valid and ID_Ready_i=0 -> next cycle IF_Valid_o=0 and IF_Instruction_o=0x00000013; the following cycle IF_PC_o=0x00400100.
- Redirect_i with target 0x00400102 -> Misaligned_o=1 and IF_Valid_o stays 0 for 5 idle cycles; redirect to 0x00400200 -> Misaligned_o=0 and the slot gets 0x00400200 one cycle later.
- Force pc to 0xFFFFFFFC via redirect -> slot IF_PC_o=0xFFFFFFFC, IF_PC_Plus4_o=0x00000000; the next slot PC is 0x00000000.
- Assert reset mid-stream with IF_Valid_o=1 -> same cycle IF_Valid_o=0, Mem_Address_o=0x00400000, Fetch_Count_o=0.
